apb_arbiter_master: RTL and testbench
=====================================

# apb_arbiter_master

Two-port APB master that shares one APB bus between two local requesters and sequences each request through the APB SETUP/ACCESS phases toward the memory-mapped slave. Round-robin arbitration, per-request completion pulse with read data, and an ACCESS-phase timeout that turns a slave that never asserts PREADY into an error completion. Sits between the core-side requesters and the APB slave port.

## Interface
- ADDR_W, 32, address width of requester and APB address buses
- DATA_W, 32, data width of write/read buses
- TIMEOUT, 16, maximum ACCESS-phase cycles before abort (≥2)

- PCLK  in  1  APB clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- req0 / req1  in  1  transfer request; held high until done of that port
- wr0 / wr1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  transfer address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle, coincident with done: transfer timed out
- rdata0 / rdata1  out  DATA_W  read data, valid with done on reads; holds until next read completion on that port
- busy  out  1  high in any state other than IDLE
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address / write data
- PRDATA  in  DATA_W; PREADY  in  1  APB slave response

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: requests sampled only here. None → stay. One → grant it. Both → grant port not in last_grant. On grant: latch wr/addr/wdata into PWRITE/PADDR/PWDATA, record grant index, last_grant ← index, go SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally → ACCESS; timeout counter cleared to 0.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 → capture PRDATA into granted port's rdata if read, go DONE with err=0. PREADY=0 and counter==TIMEOUT-1 → go DONE with err=1, rdata unchanged. Else counter+1, stay.
- PREADY=1 on the final allowed cycle wins over timeout (success).
- DONE: PSEL=0, PENABLE=0; done (and err if aborted) high for granted port only; → IDLE.
- PADDR/PWDATA/PWRITE hold last values outside transfers; req/addr changes after grant ignored; req dropped mid-transfer does not cancel it.
- A requester keeping req high after its done is a new request, arbitrated in the following IDLE.
- Counter width clog2(TIMEOUT); no wrap reachable.

## Timing
- Reset (PRESETn low at a PCLK edge): state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, done*=0, err*=0, rdata*=0, busy=0, last_grant=1 (port 0 wins first tie). Reset mid-transfer aborts with no done/err.
- All outputs registered. Latency req→PSEL: 1 cycle (req seen in IDLE at edge N, PSEL high cycle N+1).
- Zero-wait slave: SETUP 1 + ACCESS 1 + DONE 1 + IDLE 1 = 4 cycles per transfer; done one cycle after PREADY sampled high.
- Wait states: each PREADY=0 ACCESS cycle adds 1; max ACCESS length TIMEOUT cycles.
- Two continuous requesters alternate strictly 0,1,0,1,…

## Test plan
- Reset then req0 write addr=0x4 wdata=0xDEADBEEF, PREADY=1 -> PSEL 1 cycle after req, PENABLE next cycle with PADDR=0x4 PWDATA=0xDEADBEEF PWRITE=1, done0 pulse 1 cycle later, err0=0.
- req1 read addr=0x4 after above, PRDATA=0xDEADBEEF -> done1 with rdata1=0xDEADBEEF, rdata0 unchanged, done0 stays 0.
- req0 and req1 asserted same cycle and held through 4 transfers -> grant order 0,1,0,1; each transfer 4 cycles.
- PREADY held low 3 ACCESS cycles then high (TIMEOUT=16) -> ACCESS lasts 4 cycles, done without err, read data captured on the PREADY cycle.
- PREADY stuck low, TIMEOUT=16 -> exactly 16 ACCESS cycles, then done0 and err0 together, PSEL drops, rdata0 unchanged; PREADY rising on cycle 16 instead -> success.
- PRESETn low during ACCESS -> next cycle PSEL=PENABLE=0, busy=0, no done; after release req0 wins a tie.

Source files
------------

// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// per-port completion pulse with read data and an ACCESS-phase timeout.
module apb_arbiter_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_grant;
    logic              r_psel, r_penable, r_pwrite, r_busy;
    logic              r_done0, r_done1, r_err0, r_err1;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata, r_rdata0, r_rdata1;

    logic w_req_any, w_grant_idx, w_timeout, w_finish;
    logic w_psel_nxt, w_penable_nxt, w_busy_nxt;
    logic w_done0_nxt, w_done1_nxt, w_err0_nxt, w_err1_nxt, w_cap0, w_cap1;

    // r_grant doubles as last_grant; reset to 1 so port 0 wins the first tie
    assign w_req_any   = req0 | req1;
    assign w_grant_idx = (req0 & req1) ? ~r_grant : req1;
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (PREADY || w_timeout) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        w_finish      = (r_state == S_ACCESS) && (PREADY || w_timeout);
        w_psel_nxt    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
        w_penable_nxt = (w_state_nxt == S_ACCESS);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done0_nxt   = w_finish && !r_grant;
        w_done1_nxt   = w_finish &&  r_grant;
        w_err0_nxt    = w_done0_nxt && !PREADY;
        w_err1_nxt    = w_done1_nxt && !PREADY;
        w_cap0        = (r_state == S_ACCESS) && PREADY && !r_pwrite && !r_grant;
        w_cap1        = (r_state == S_ACCESS) && PREADY && !r_pwrite &&  r_grant;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_cnt     <= '0;
            r_grant   <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_busy    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_busy    <= w_busy_nxt;
            r_done0   <= w_done0_nxt;
            r_done1   <= w_done1_nxt;
            r_err0    <= w_err0_nxt;
            r_err1    <= w_err1_nxt;
            if (r_state == S_IDLE && w_req_any) begin
                r_grant  <= w_grant_idx;
                r_pwrite <= w_grant_idx ? wr1    : wr0;
                r_paddr  <= w_grant_idx ? addr1  : addr0;
                r_pwdata <= w_grant_idx ? wdata1 : wdata0;
            end
            if (r_state == S_SETUP)
                r_cnt <= '0;
            else if (r_state == S_ACCESS && !PREADY && !w_timeout)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_cap0) r_rdata0 <= PRDATA;
            if (w_cap1) r_rdata1 <= PRDATA;
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign busy    = r_busy;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Scoreboard bench for apb_arbiter_master: directed transfers against a small
// APB slave model with programmable wait states.
module tb_apb_arbiter_master;
    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    apb_arbiter_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          port;
        bit          err;
        bit          upd;
        logic [31:0] rdata;
        int          acc;
        bit          gap;
    } cmp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
    } apb_t;

    cmp_t cmp_q[$];
    apb_t apb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int slv_wait = 0;
    int acc_cnt = 0;
    int acc_len = 0;
    int last_done = 0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    logic [31:0] mem [logic [31:0]];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge PCLK) cyc <= cyc + 1;

    // APB slave: PREADY after slv_wait low ACCESS cycles; junk PRDATA until ready
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (acc_cnt == slv_wait) begin
                PREADY = 1'b1;
                if (PWRITE) mem[PADDR] = PWDATA;
                PRDATA = mem.exists(PADDR) ? mem[PADDR] : 32'h0;
            end else begin
                PREADY = 1'b0;
                PRDATA = 32'hBAD0_0000 | 32'(acc_cnt);
            end
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'h0;
            acc_cnt = 0;
        end
    end

    // monitor: pops expectations when the DUT starts a SETUP or completes
    always @(negedge PCLK) begin
        apb_t a;
        cmp_t e;
        if (!PRESETn) begin
            m_rd0 = '0;
            m_rd1 = '0;
        end
        if (PSEL && !PENABLE) begin
            acc_len = 0;
            if (apb_q.size() == 0) begin
                check("unexpected_setup", 1, 0);
            end else begin
                a = apb_q.pop_front();
                check("paddr", 64'(PADDR), 64'(a.addr));
                check("pwrite", 64'(PWRITE), 64'(a.wr));
                if (a.wr) check("pwdata", 64'(PWDATA), 64'(a.wdata));
            end
        end else if (PSEL && PENABLE) begin
            acc_len++;
        end
        if (done0 || done1) begin
            if (cmp_q.size() == 0) begin
                check("unexpected_done", 64'({done1, done0}), 0);
            end else begin
                e = cmp_q.pop_front();
                check("done_vec", 64'({done1, done0}), e.port ? 64'h2 : 64'h1);
                check("err_vec", 64'({err1, err0}), e.err ? (e.port ? 64'h2 : 64'h1) : 64'h0);
                check("access_len", 64'(acc_len), 64'(e.acc));
                if (e.gap) check("xfer_cycles", 64'(cyc - last_done), 64'd4);
                if (e.upd) begin
                    if (e.port) m_rd1 = e.rdata;
                    else        m_rd0 = e.rdata;
                end
                check("rdata0", 64'(rdata0), 64'(m_rd0));
                check("rdata1", 64'(rdata1), 64'(m_rd1));
            end
            last_done = cyc;
        end
    end

    task automatic expect_xfer(input bit port, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit err,
                               input logic [31:0] rd, input int acc, input bit gap);
        apb_t a;
        cmp_t e;
        a.addr = addr; a.wr = wr; a.wdata = wdata;
        e.port = port; e.err = err; e.upd = !wr && !err; e.rdata = rd; e.acc = acc; e.gap = gap;
        apb_q.push_back(a);
        cmp_q.push_back(e);
    endtask

    task automatic set_port(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin wr1 = wr; addr1 = addr; wdata1 = wdata; end
        else      begin wr0 = wr; addr0 = addr; wdata0 = wdata; end
    endtask

    // single transfer on one port; optional cycle-exact latency checks
    task automatic xfer(input bit port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wt, input bit err,
                        input logic [31:0] rd, input int acc, input bit lat);
        int n;
        bit seen;
        expect_xfer(port, wr, addr, wdata, err, rd, acc, 1'b0);
        slv_wait = wt;
        set_port(port, wr, addr, wdata);
        if (port) req1 = 1'b1; else req0 = 1'b1;
        if (lat) begin
            @(negedge PCLK);
            check("psel_not_early", 64'(PSEL), 0);
            @(negedge PCLK);
            check("setup_ctrl", 64'({PSEL, PENABLE, busy}), 64'b101);
            @(negedge PCLK);
            check("access_ctrl", 64'({PSEL, PENABLE}), 64'b11);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge PCLK);
            n++;
            seen = port ? done1 : done0;
        end
        if (!seen) check("done_wait_timeout", 0, 1);
        @(posedge PCLK); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic both_req(input int n);
        int cnt;
        int bound;
        slv_wait = 0;
        req0 = 1'b1;
        req1 = 1'b1;
        cnt = 0;
        bound = 0;
        while (cnt < n && bound < n * 20) begin
            @(negedge PCLK);
            bound++;
            if (done0 || done1) cnt++;
        end
        if (cnt < n) check("tie_wait_timeout", 64'(cnt), 64'(n));
        @(posedge PCLK); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, done0, done1, err0, err1}), 0);
        check("reset_paddr", 64'(PADDR), 0);
        check("reset_rdata", 64'({rdata1, rdata0}), 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // write then read back from the other port
        xfer(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1, 1'b1);
        xfer(1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1, 1'b0);

        // both requesting: strict alternation starting with port 0
        set_port(1'b0, 1'b0, 32'h4, 32'h0);
        set_port(1'b1, 1'b1, 32'h10, 32'h1111_0000);
        expect_xfer(1'b0, 1'b0, 32'h4,  32'h0,         1'b0, 32'hDEADBEEF, 1, 1'b0);
        expect_xfer(1'b1, 1'b1, 32'h10, 32'h1111_0000, 1'b0, 32'h0,        1, 1'b1);
        expect_xfer(1'b0, 1'b0, 32'h4,  32'h0,         1'b0, 32'hDEADBEEF, 1, 1'b1);
        expect_xfer(1'b1, 1'b1, 32'h10, 32'h1111_0000, 1'b0, 32'h0,        1, 1'b1);
        both_req(4);

        // three wait states, data taken on the PREADY cycle
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h1111_0000, 4, 1'b0);
        // stuck slave: 16 ACCESS cycles then error, rdata0 keeps DEADBEEF
        xfer(1'b0, 1'b0, 32'h8, 32'h0, 1000, 1'b1, 32'h0, 16, 1'b0);
        // PREADY on the last allowed cycle still succeeds
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 15, 1'b0, 32'h1111_0000, 16, 1'b0);

        // reset in the middle of an ACCESS phase
        apb_q.push_back('{addr: 32'h20, wr: 1'b1, wdata: 32'h5A5A_5A5A});
        slv_wait = 1000;
        set_port(1'b0, 1'b1, 32'h20, 32'h5A5A_5A5A);
        req0 = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PENABLE && n < 20);
        if (!PENABLE) check("access_wait_timeout", 0, 1);
        repeat (2) @(negedge PCLK);
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        req0 = 1'b0;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("midreset_ctrl", 64'({PSEL, PENABLE, busy, done0, done1, err0, err1}), 0);
        check("midreset_rdata", 64'({rdata1, rdata0}), 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // after reset port 0 wins the tie again
        set_port(1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1'b1, 1'b0, 32'h4, 32'h0);
        expect_xfer(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_0000, 1, 1'b0);
        expect_xfer(1'b1, 1'b0, 32'h4,  32'h0, 1'b0, 32'hDEADBEEF,  1, 1'b1);
        both_req(2);

        repeat (4) @(negedge PCLK);
        check("cmp_q_drained", 64'(cmp_q.size()), 0);
        check("apb_q_drained", 64'(apb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
